// File: rtl/line_buffer_ctrl.sv
// Line-buffer front-end: captures one line from an upstream pixel stream into a
// single-port line RAM, then plays it back forward or mirrored downstream.
module line_buffer_ctrl #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 30,
    parameter int unsigned LINE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mirror,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_line_done,
    output logic                  o_ram_cs,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_din,
    input  logic [DATA_WIDTH-1:0] i_ram_dout
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LINE_LEN = CNT_W'(LINE_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WIDTH - 1);

    typedef enum logic {
        S_WRITE = 1'b0,
        S_READ  = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic                  r_mirror;

    logic                  w_wr_hs;
    logic                  w_load;
    logic                  w_rd_last;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    assign o_ready   = (r_state == S_WRITE);
    assign w_wr_hs   = o_ready && i_valid;
    assign w_load    = (r_state == S_READ) && (r_rd_cnt < LINE_LEN) && (!o_valid || i_ready);
    assign w_rd_last = (r_state == S_READ) && (r_rd_cnt == LINE_LEN) && o_valid && i_ready;
    assign w_rd_addr = r_mirror ? ADDR_WIDTH'(LAST_IDX - r_rd_cnt) : r_rd_cnt[ADDR_WIDTH-1:0];

    // RAM port mux: write side owns the RAM in WRITE, read side only on a load
    always_comb begin
        o_ram_cs   = 1'b0;
        o_ram_we   = 1'b0;
        o_ram_addr = '0;
        o_ram_din  = '0;
        if (r_state == S_WRITE) begin
            o_ram_cs   = i_valid;
            o_ram_we   = 1'b1;
            o_ram_addr = r_wr_cnt[ADDR_WIDTH-1:0];
            o_ram_din  = i_data;
        end else begin
            o_ram_cs   = w_load;
            o_ram_addr = w_rd_addr;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_WRITE;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_mirror    <= 1'b0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_line_done <= 1'b0;
        end else begin
            o_line_done <= 1'b0;
            case (r_state)
                S_WRITE: begin
                    if (w_wr_hs) begin
                        if (r_wr_cnt == '0) begin
                            r_mirror <= i_mirror;
                        end
                        if (r_wr_cnt == LAST_IDX) begin
                            r_state  <= S_READ;
                            r_wr_cnt <= '0;
                            r_rd_cnt <= '0;
                        end else begin
                            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    // Output register doubles as a one-entry skid: refill only when empty or draining
                    if (w_load) begin
                        o_data   <= i_ram_dout;
                        o_valid  <= 1'b1;
                        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                    end else if (w_rd_last) begin
                        r_state     <= S_WRITE;
                        o_valid     <= 1'b0;
                        o_line_done <= 1'b1;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: r_state <= S_WRITE;
            endcase
        end
    end

endmodule
